// File: rtl/gray_input_sampler.sv
// gray_input_sampler: synchronises an asynchronous Gray-coded bus into clk, debounces it and
// publishes a new code only after it has been stable for STABLE_CYCLES samples. Accepted codes
// that are not a single-bit step from the previous one raise step_err.
// Optional feature: define GRAY_SAMPLER_ERRCNT_EN to build the saturating step_err counter;
// without it err_count is tied to zero.
module gray_input_sampler #(
    parameter int unsigned N             = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] gray_in,
    input  logic         sample_en,
    output logic [N-1:0] gray_out,
    output logic         gray_valid,
    output logic         step_err,
    output logic [7:0]   err_count
);

    localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned PopW = $clog2(N + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    typedef enum logic {StIdle, StSettle} state_t;

    logic [N-1:0]    r_sync [SYNC_STAGES];
    state_t          r_state;
    logic [N-1:0]    r_cand;
    logic [CntW-1:0] r_cnt;
    logic [N-1:0]    r_gray_out;
    logic            r_valid;
    logic            r_step_err;
    logic            r_first_done;

    logic [N-1:0]    w_sync;
    logic [N-1:0]    w_delta;
    logic [PopW-1:0] w_diff_bits;
    logic            w_step_bad;

    // Synchroniser chain; free-running so the filter always sees a fresh sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign w_delta = r_cand ^ r_gray_out;

    // Number of bits the candidate differs from the currently published code.
    always_comb begin
        w_diff_bits = '0;
        for (int i = 0; i < N; i++) begin
            w_diff_bits = w_diff_bits + PopW'(w_delta[i]);
        end
    end

    // The very first acceptance after reset has no meaningful predecessor.
    assign w_step_bad = r_first_done && (w_diff_bits != PopW'(1));

    // Debounce FSM with registered publish/pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_cand       <= '0;
            r_cnt        <= '0;
            r_gray_out   <= '0;
            r_valid      <= 1'b0;
            r_step_err   <= 1'b0;
            r_first_done <= 1'b0;
        end else begin
            r_valid    <= 1'b0;
            r_step_err <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (sample_en && (w_sync != r_gray_out)) begin
                        r_state <= StSettle;
                        r_cand  <= w_sync;
                        r_cnt   <= CntOne;
                    end
                end
                StSettle: begin
                    if (!sample_en) begin
                        r_state <= StIdle;
                    end else if (w_sync == r_gray_out) begin
                        // Input fell back to the published code: treat as a glitch.
                        r_state <= StIdle;
                    end else if (w_sync != r_cand) begin
                        r_cand <= w_sync;
                        r_cnt  <= CntOne;
                    end else if (r_cnt == CntMax) begin
                        r_gray_out   <= r_cand;
                        r_valid      <= 1'b1;
                        r_step_err   <= w_step_bad;
                        r_first_done <= 1'b1;
                        r_state      <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + CntOne;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef GRAY_SAMPLER_ERRCNT_EN
    logic       w_accept;
    logic [7:0] r_err_count;

    // Mirrors the FSM accept condition so the count moves on the same edge as step_err.
    assign w_accept = (r_state == StSettle) && sample_en && (w_sync != r_gray_out) &&
                      (w_sync == r_cand) && (r_cnt == CntMax);

    // Saturating count of step errors; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= 8'd0;
        end else if (w_accept && w_step_bad && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = 8'd0;
`endif

    assign gray_out   = r_gray_out;
    assign gray_valid = r_valid;
    assign step_err   = r_step_err;

endmodule

// File: tb/tb_gray_input_sampler.sv
// Self-checking bench for gray_input_sampler. The reference model works on run lengths of the
// synchronised input: a code is published once it has been seen on STABLE_CYCLES+1 consecutive
// enabled edges while differing from the published code.
module tb_gray_input_sampler;

    localparam int N  = 4;
    localparam int SS = 2;
    localparam int SC = 4;
`ifdef GRAY_SAMPLER_ERRCNT_EN
    localparam bit ErrCntEn = 1'b1;
`else
    localparam bit ErrCntEn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] gray_in = '0;
    logic         sample_en = 1'b1;
    logic [N-1:0] gray_out;
    logic         gray_valid;
    logic         step_err;
    logic [7:0]   err_count;

    gray_input_sampler #(
        .N             (N),
        .SYNC_STAGES   (SS),
        .STABLE_CYCLES (SC)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gray_in    (gray_in),
        .sample_en  (sample_en),
        .gray_out   (gray_out),
        .gray_valid (gray_valid),
        .step_err   (step_err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [N-1:0] m_hist[$];
    logic [N-1:0] m_out;
    logic         m_valid;
    logic         m_err;
    logic         m_first;
    int           m_run;
    logic [N-1:0] m_runval;
    int           m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int popcnt(input logic [N-1:0] x);
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(x[i]);
        return c;
    endfunction

    task automatic model_reset();
        m_hist = {};
        for (int i = 0; i < SS; i++) m_hist.push_back('0);
        m_out   = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_first = 1'b0;
        m_run   = 0;
        m_runval = '0;
        m_cnt   = 0;
    endtask

    // One clock edge of the reference: s is what the synchroniser presents at this edge.
    task automatic model_edge();
        logic [N-1:0] s;
        s = m_hist.pop_front();
        m_hist.push_back(gray_in);
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (!sample_en || s == m_out) begin
            m_run = 0;
        end else if (m_run > 0 && s == m_runval) begin
            m_run++;
        end else begin
            m_run = 1;
            m_runval = s;
        end
        if (m_run == SC + 1) begin
            m_err = m_first && (popcnt(s ^ m_out) != 1);
            if (ErrCntEn && m_err && m_cnt < 255) m_cnt++;
            m_out   = s;
            m_valid = 1'b1;
            m_first = 1'b1;
            m_run   = 0;
        end
    endtask

    task automatic compare_all();
        check_eq("gray_out", 32'(gray_out), 32'(m_out));
        check_eq("gray_valid", 32'(gray_valid), 32'(m_valid));
        check_eq("step_err", 32'(step_err), 32'(m_err));
        check_eq("err_count", 32'(err_count), 32'(m_cnt));
    endtask

    // Starts and ends on a negedge; inputs change only there.
    task automatic step(input logic [N-1:0] v, input logic en);
        gray_in   = v;
        sample_en = en;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic hold(input logic [N-1:0] v, input logic en, input int n);
        for (int i = 0; i < n; i++) step(v, en);
    endtask

    task automatic apply_reset(input logic [N-1:0] v);
        @(negedge clk);
        #2;
        rst_n   = 1'b0;
        gray_in = v;
        #1;
        check_eq("rst_gray_out", 32'(gray_out), 32'd0);
        check_eq("rst_valid", 32'(gray_valid), 32'd0);
        check_eq("rst_step_err", 32'(step_err), 32'd0);
        check_eq("rst_err_count", 32'(err_count), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int first_idx;
        logic [N-1:0] last_v;
        logic [N-1:0] v;

        model_reset();
        apply_reset(4'b0000);

        // Quiet input: nothing published
        hold(4'b0000, 1'b1, 50);

        // Power-up code published after the pipeline latency, never flagged
        apply_reset(4'b0110);
        first_idx = -1;
        for (int i = 1; i <= 12; i++) begin
            step(4'b0110, 1'b1);
            if (gray_valid && first_idx < 0) first_idx = i;
        end
        // Input stable before the first edge after release (k=1) -> published at k+SS+SC
        check_eq("first_latency", 32'(first_idx), 32'(1 + SS + SC));
        check_eq("first_code", 32'(gray_out), 32'b0110);

        // Legal single-bit steps from zero
        apply_reset(4'b0000);
        hold(4'b0000, 1'b1, 4);
        hold(4'b0001, 1'b1, 10);
        hold(4'b0011, 1'b1, 10);
        hold(4'b0001, 1'b1, 10);

        // Short pulse rejected
        hold(4'b0011, 1'b1, 3);
        hold(4'b0001, 1'b1, 10);
        check_eq("glitch_hold", 32'(gray_out), 32'b0001);

        // Illegal jump, then many to saturate the counter
        hold(4'b0111, 1'b1, 10);
        for (int i = 0; i < 300; i++) begin
            hold((i % 2 == 0) ? 4'b0001 : 4'b0111, 1'b1, 8);
        end
        check_eq("err_saturated", 32'(err_count), ErrCntEn ? 32'd255 : 32'd0);

        // sample_en dropped mid-settle, then raised with input held
        hold(4'b0011, 1'b1, 4);
        hold(4'b0011, 1'b0, 4);
        first_idx = -1;
        for (int i = 1; i <= 10; i++) begin
            step(4'b0011, 1'b1);
            if (gray_valid && first_idx < 0) first_idx = i;
        end
        check_eq("en_latency", 32'(first_idx), 32'(SC + 1));

        // Reset asserted while a new code is settling
        hold(4'b0110, 1'b1, 4);
        apply_reset(4'b0110);
        hold(4'b0110, 1'b1, 10);

        // Randomised segments: mostly single-bit moves, some jumps and enable drops
        last_v = gray_out;
        for (int seg = 0; seg < 300; seg++) begin
            if ($urandom_range(0, 3) == 0) v = 4'($urandom_range(0, 15));
            else v = last_v ^ (4'b0001 << $urandom_range(0, N - 1));
            hold(v, ($urandom_range(0, 9) != 0), $urandom_range(1, 8));
            last_v = v;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
